// File: rtl/unit_input_buf_pkg.sv
// Shared types and constants for the per-unit input stage.
package unit_input_buf_pkg;

    localparam int N_THREADS_DEF   = 16;
    localparam int SLOT_WORDS_DEF  = 32;
    localparam int PKT_MAX_LEN_DEF = 104;
    localparam int PKT_MIN_LEN_DEF = 40;
    localparam int FIFO_DEPTH_DEF  = 4;

    // Header type codes shared with the transmit arbiter
    localparam logic [2:0] PKT_HDR_DATA = 3'b000;
    localparam logic [2:0] PKT_HDR_INIT = 3'b001;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    function automatic logic [2:0] hdr_type(input byte_t b);
        return b[2:0];
    endfunction

    function automatic logic [4:0] hdr_entry(input byte_t b);
        return b[7:3];
    endfunction

endpackage

// File: rtl/unit_input_buf_if.sv
// Byte broadcast link between the transmit arbiter and one unit input stage.
interface unit_input_buf_if;
    import unit_input_buf_pkg::*;

    byte_t in_data;
    logic  in_ctrl;
    logic  in_wr_en;
    logic  in_afull;
    logic  in_ready;

    modport master (output in_data, in_ctrl, in_wr_en, input in_afull, in_ready);
    modport slave  (input in_data, in_ctrl, in_wr_en, output in_afull, in_ready);
endinterface

// File: rtl/unit_input_buf_fifo.sv
// Small staging FIFO between the byte packer and the slot memory write port.
module unit_input_fifo
    import unit_input_buf_pkg::*;
#(
    parameter int WIDTH = 42,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Entry storage; a push into a full FIFO is discarded here
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/unit_input_buf.sv
// Per-unit input stage: header decode, LE word packing, slot allocation and slot memory.
module unit_input_buf
    import unit_input_buf_pkg::*;
#(
    parameter int N_THREADS   = N_THREADS_DEF,
    parameter int SLOT_WORDS  = SLOT_WORDS_DEF,
    parameter int PKT_MAX_LEN = PKT_MAX_LEN_DEF,
    parameter int PKT_MIN_LEN = PKT_MIN_LEN_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    localparam int THR_W = $clog2(N_THREADS),
    localparam int IDX_W = $clog2(SLOT_WORDS)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    unit_input_buf_if.slave      in_bus,
    output logic [4:0]           entry_pt,
    output logic                 entry_pt_set,
    output logic [N_THREADS-1:0] thread_loaded,
    input  logic                 rd_en,
    input  logic [THR_W-1:0]     rd_thread,
    input  logic [IDX_W-1:0]     rd_addr,
    output logic [31:0]          dout,
    input  logic                 release_en,
    input  logic [THR_W-1:0]     release_thread,
    output logic                 err
);
    localparam int CNT_W  = $clog2(PKT_MAX_LEN + 1);
    localparam int ENT_W  = 1 + THR_W + IDX_W + 32;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    state_t               state;
    logic [N_THREADS-1:0] busy;
    logic [THR_W-1:0]     cur_slot;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     total;
    logic [23:0]          acc;

    logic byte_v, is_hdr, any_free, alloc_fire, at_max, overflow, final_bad;
    logic push, pop, rel_err, ovf_err;
    logic [THR_W-1:0]     alloc_idx;
    logic [N_THREADS-1:0] alloc_mask, free_mask, rel_mask, load_mask;

    logic [ENT_W-1:0]  push_ent;
    logic [ENT_W-1:0]  fifo_dout;
    logic [FCNT_W-1:0] fifo_count;
    logic              fifo_empty, fifo_full;
    logic              f_last;
    logic [THR_W-1:0]  f_slot;
    logic [IDX_W-1:0]  f_idx;
    logic [31:0]       f_data;

    logic [31:0] mem [N_THREADS * SLOT_WORDS];

    assign byte_v   = in_bus.in_wr_en;
    assign is_hdr   = byte_v & in_bus.in_ctrl;
    assign any_free = |(~busy);

    // Lowest-index free slot, taken from the mask before any same-cycle release
    always_comb begin
        alloc_idx = '0;
        for (int i = N_THREADS - 1; i >= 0; i--) begin
            if (!busy[i]) alloc_idx = THR_W'(i);
        end
    end

    assign alloc_fire = (state == ST_IDLE) & is_hdr &
                        (hdr_type(in_bus.in_data) == PKT_HDR_DATA) & any_free;
    assign total      = cnt + CNT_W'(1);
    assign at_max     = (cnt == CNT_W'(PKT_MAX_LEN));
    assign overflow   = (state == ST_RECV) & byte_v & at_max;
    assign final_bad  = (state == ST_RECV) & is_hdr & ~at_max &
                        ((total[1:0] != 2'b00) | (total < CNT_W'(PKT_MIN_LEN)));
    // Every 4th byte closes a word; a rejected final byte closes nothing
    assign push       = (state == ST_RECV) & byte_v & ~at_max &
                        (cnt[1:0] == 2'b11) & ~final_bad;
    assign push_ent   = {in_bus.in_ctrl, cur_slot, IDX_W'(cnt >> 2), in_bus.in_data, acc};

    assign pop    = ~fifo_empty & ~rd_en;
    assign f_last = fifo_dout[ENT_W-1];
    assign f_slot = fifo_dout[ENT_W-2 -: THR_W];
    assign f_idx  = fifo_dout[32 +: IDX_W];
    assign f_data = fifo_dout[31:0];

    assign alloc_mask = alloc_fire ? (N_THREADS'(1) << alloc_idx) : '0;
    assign free_mask  = (overflow | final_bad) ? (N_THREADS'(1) << cur_slot) : '0;
    assign rel_mask   = release_en ? (N_THREADS'(1) << release_thread) : '0;
    assign load_mask  = (pop & f_last) ? (N_THREADS'(1) << f_slot) : '0;
    assign rel_err    = release_en & ~thread_loaded[release_thread];
    assign ovf_err    = push & fifo_full;

    // Flow control seen by the arbiter; the afull margin absorbs its 3-cycle loop
    assign in_bus.in_afull = (fifo_count >= FCNT_W'(FIFO_DEPTH - 2));
    assign in_bus.in_ready = (state == ST_IDLE) & any_free & fifo_empty;

    unit_input_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (push),
        .din   (push_ent),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Packet FSM with slot allocation, entry point capture and sticky error
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= ST_IDLE;
            busy         <= '0;
            cur_slot     <= '0;
            cnt          <= '0;
            entry_pt     <= '0;
            entry_pt_set <= 1'b0;
            err          <= 1'b0;
        end else begin
            entry_pt_set <= 1'b0;
            busy         <= (busy | alloc_mask) & ~free_mask & ~rel_mask;
            if (rel_err || ovf_err) err <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (is_hdr) begin
                        if (hdr_type(in_bus.in_data) == PKT_HDR_DATA) begin
                            if (any_free) begin
                                cur_slot <= alloc_idx;
                                cnt      <= '0;
                                state    <= ST_RECV;
                            end else begin
                                err   <= 1'b1;
                                state <= ST_DROP;
                            end
                        end else if (hdr_type(in_bus.in_data) == PKT_HDR_INIT) begin
                            entry_pt     <= hdr_entry(in_bus.in_data);
                            entry_pt_set <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (byte_v) begin
                        err <= 1'b1;
                    end
                end
                ST_RECV: begin
                    if (overflow) begin
                        err   <= 1'b1;
                        state <= in_bus.in_ctrl ? ST_IDLE : ST_DROP;
                    end else if (is_hdr) begin
                        if (final_bad) err <= 1'b1;
                        state <= ST_IDLE;
                    end else if (byte_v) begin
                        cnt <= total;
                    end
                end
                ST_DROP: begin
                    if (is_hdr) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Little-endian accumulation of the first three bytes of each word
    always_ff @(posedge CLK) begin
        if (state == ST_RECV && byte_v && !in_bus.in_ctrl) begin
            case (cnt[1:0])
                2'b00:   acc[7:0]   <= in_bus.in_data;
                2'b01:   acc[15:8]  <= in_bus.in_data;
                2'b10:   acc[23:16] <= in_bus.in_data;
                default: acc        <= acc;
            endcase
        end
    end

    // Loaded mask: set when a packet's last word lands, cleared on release
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) thread_loaded <= '0;
        else        thread_loaded <= (thread_loaded | load_mask) & ~rel_mask;
    end

    // Slot memory write port, fed from the FIFO when the core is not reading
    always_ff @(posedge CLK) begin
        if (pop) mem[{f_slot, f_idx}] <= f_data;
    end

    // Core read port, one cycle latency
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)     dout <= '0;
        else if (rd_en) dout <= mem[{rd_thread, rd_addr}];
    end
endmodule

// File: tb/tb_unit_input_buf.sv
// Directed bench for unit_input_buf with a read-data scoreboard.
module tb_unit_input_buf;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    unit_input_buf_if bus();

    logic [4:0]  entry_pt;
    logic        entry_pt_set;
    logic [15:0] thread_loaded;
    logic        rd_en;
    logic [3:0]  rd_thread;
    logic [4:0]  rd_addr;
    logic [31:0] dout;
    logic        release_en;
    logic [3:0]  release_thread;
    logic        err;

    unit_input_buf dut (
        .CLK            (clk),
        .RST_N          (rst_n),
        .in_bus         (bus),
        .entry_pt       (entry_pt),
        .entry_pt_set   (entry_pt_set),
        .thread_loaded  (thread_loaded),
        .rd_en          (rd_en),
        .rd_thread      (rd_thread),
        .rd_addr        (rd_addr),
        .dout           (dout),
        .release_en     (release_en),
        .release_thread (release_thread),
        .err            (err)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic        rd_pend;
    logic        afull_seen;

    always @(posedge clk) rd_pend <= rd_en;

    always @(negedge clk) if (bus.in_afull === 1'b1) afull_seen = 1'b1;

    // Scoreboard monitor: every read issued one cycle ago is compared here
    always @(negedge clk) begin
        if (rd_pend === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data: dout=%h with no expected entry", dout);
            end else begin
                if (dout !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rd_data: got %h expected %h", dout, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] exp_word(input logic [7:0] seed, input int w);
        logic [7:0] b0;
        b0 = seed + 8'(4 * w);
        return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic ctrl, input logic [7:0] d);
        int n = 0;
        while (bus.in_afull !== 1'b0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL afull_timeout: in_afull=%b, required 0", bus.in_afull);
        end
        bus.in_ctrl  = ctrl;
        bus.in_data  = d;
        bus.in_wr_en = 1'b1;
        @(posedge clk); #1;
        bus.in_wr_en = 1'b0;
        bus.in_ctrl  = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] seed, input int len);
        send_byte(1'b1, 8'h00);
        for (int i = 0; i < len; i++) send_byte(i == len - 1, seed + 8'(i));
    endtask

    task automatic rd_word(input logic [3:0] thr, input logic [4:0] addr, input logic [31:0] exp);
        rd_thread = thr;
        rd_addr   = addr;
        rd_en     = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic rd_pkt(input logic [3:0] thr, input logic [7:0] seed, input int nw);
        for (int w = 0; w < nw; w++) rd_word(thr, 5'(w), exp_word(seed, w));
    endtask

    task automatic rel(input logic [3:0] t);
        release_thread = t;
        release_en     = 1'b1;
        @(posedge clk); #1;
        release_en = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; bus.in_data = 8'h00; bus.in_ctrl = 1'b0; bus.in_wr_en = 1'b0;
        rd_en = 1'b0; rd_thread = '0; rd_addr = '0; release_en = 1'b0; release_thread = '0;
        afull_seen = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", bus.in_ready, 1);
        chk("reset_afull", bus.in_afull, 0);
        chk("reset_loaded", thread_loaded, 0);
        chk("reset_err", err, 0);
        chk("reset_entry", entry_pt, 0);
        chk("reset_entry_set", entry_pt_set, 0);
        chk("reset_dout", dout, 0);

        // 40-byte packet lands in slot 0
        send_pkt(8'h00, 40);
        settle(8);
        chk("p40_loaded", thread_loaded, 16'h0001);
        chk("p40_err", err, 0);
        chk("p40_ready", bus.in_ready, 1);
        rd_word(4'd0, 5'd0, 32'h03020100);
        rd_word(4'd0, 5'd9, 32'h27262524);
        rd_pkt(4'd0, 8'h00, 10);

        // Init byte twice
        send_byte(1'b1, 8'h51);
        @(negedge clk);
        chk("init1_entry", entry_pt, 10);
        chk("init1_set", entry_pt_set, 1);
        chk("init1_ready", bus.in_ready, 1);
        @(negedge clk);
        chk("init_set_clear", entry_pt_set, 0);
        send_byte(1'b1, 8'h51);
        @(negedge clk);
        chk("init2_entry", entry_pt, 10);
        chk("init2_set", entry_pt_set, 1);
        chk("init2_ready", bus.in_ready, 1);
        chk("init_err", err, 0);

        // 104-byte packet with the core hogging the memory port for 20 cycles
        afull_seen = 1'b0;
        fork
            send_pkt(8'h40, 104);
            begin
                repeat (12) @(posedge clk);
                @(negedge clk);
                chk("recv_not_ready", bus.in_ready, 0);
                @(posedge clk); #1;
                for (int i = 0; i < 20; i++) rd_word(4'd0, 5'd3, 32'h0F0E0D0C);
            end
        join
        settle(10);
        chk("stall_afull_seen", afull_seen, 1);
        chk("stall_afull_low", bus.in_afull, 0);
        chk("stall_loaded", thread_loaded, 16'h0003);
        chk("stall_err", err, 0);
        chk("stall_ready", bus.in_ready, 1);
        rd_word(4'd1, 5'd25, 32'hA7A6A5A4);
        rd_pkt(4'd1, 8'h40, 26);

        // Fill the remaining 14 slots
        for (int k = 0; k < 14; k++) send_pkt(8'(16 * k + 5), 40);
        settle(8);
        chk("full_loaded", thread_loaded, 16'hFFFF);
        chk("full_ready", bus.in_ready, 0);
        chk("full_err", err, 0);
        rd_word(4'd2, 5'd0, 32'h08070605);
        rd_word(4'd15, 5'd0, 32'hD8D7D6D5);
        rd_word(4'd15, 5'd9, 32'hFCFBFAF9);

        // 17th packet has nowhere to go
        send_pkt(8'hEE, 40);
        settle(8);
        chk("p17_err", err, 1);
        chk("p17_loaded", thread_loaded, 16'hFFFF);
        chk("p17_ready", bus.in_ready, 0);
        rd_word(4'd0, 5'd0, 32'h03020100);

        // Free slot 2, then send malformed packets into it
        rel(4'd2);
        @(negedge clk);
        chk("rel2_loaded", thread_loaded, 16'hFFFB);
        chk("rel2_ready", bus.in_ready, 1);
        send_pkt(8'h60, 42);
        settle(8);
        chk("p42_loaded", thread_loaded, 16'hFFFB);
        chk("p42_ready", bus.in_ready, 1);
        send_pkt(8'h70, 36);
        settle(8);
        chk("p36_loaded", thread_loaded, 16'hFFFB);
        chk("p36_ready", bus.in_ready, 1);
        send_pkt(8'h90, 40);
        settle(8);
        chk("reuse2_loaded", thread_loaded, 16'hFFFF);
        rd_pkt(4'd2, 8'h90, 10);

        // Reset in the middle of a packet
        rel(4'd3);
        send_byte(1'b1, 8'h00);
        for (int i = 0; i < 10; i++) send_byte(1'b0, 8'hA0 + 8'(i));
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_loaded", thread_loaded, 0);
        chk("mid_rst_afull", bus.in_afull, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_entry", entry_pt, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", bus.in_ready, 1);
        send_pkt(8'hB0, 40);
        settle(8);
        chk("post_rst_loaded", thread_loaded, 16'h0001);
        chk("post_rst_err", err, 0);
        rd_pkt(4'd0, 8'hB0, 10);

        // Releasing a slot that holds nothing is an error
        rel(4'd5);
        @(negedge clk);
        chk("rel_empty_err", err, 1);
        chk("rel_empty_loaded", thread_loaded, 16'h0001);

        settle(3);
        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
